// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction word layout, NOP word and fetch FSM state encoding
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 0;
  localparam logic [WORD_W-1:0] NOP_WORD = '0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x WORD_W storage, sync range-checked write, comb range-checked read (NOP when out of range)
module imem_array import cpu_pkg::*; #(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [WORD_W-1:0] rdata,
  output logic              rd_ok
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we && 32'(waddr) < 32'(DEPTH)) mem[waddr[AW-1:0]] <= wdata;
  assign rd_ok = 32'(raddr) < 32'(DEPTH);
  assign rdata = rd_ok ? mem[raddr[AW-1:0]] : NOP_WORD;
endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fetch responder returning the addressed instruction word LATENCY cycles after acceptance
module instr_mem_responder import cpu_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_req,
  input  logic [7:0]        address,
  output logic              busy,
  output logic              read_valid,
  output logic [WORD_W-1:0] instruction,
  output logic              addr_err,
  input  logic              load_en,
  input  logic [7:0]        load_addr,
  input  logic [WORD_W-1:0] load_data
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [WORD_W-1:0] rd_data, hold;
  logic rd_ok, err_hold;
  wire accept = state == IDLE && read_req;
  imem_array #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(load_en), .waddr(load_addr), .wdata(load_data),
    .raddr(address), .rdata(rd_data), .rd_ok(rd_ok)
  );
  always_comb
    nxt = state == IDLE ? (read_req ? WAIT : IDLE) :
          state == WAIT ? (cnt == 0 ? RESP : WAIT) : IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hold <= NOP_WORD;
      err_hold <= 1'b0;
      instruction <= NOP_WORD;
      addr_err <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        hold <= rd_data;
        err_hold <= !rd_ok;
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
      if (state == WAIT && nxt == RESP) begin
        instruction <= hold;
        addr_err <= err_hold;
      end
    end
  assign busy = state != IDLE;
  assign read_valid = state == RESP;
endmodule
